// File: rtl/vga_pkg.sv
// Shared constants, encodings and helpers for the VGA pattern generator.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // 3-3-2 colour words {b[1:0], g[2:0], r[2:0]}
  localparam logic [7:0] BAR_WHITE   = 8'hFF;
  localparam logic [7:0] BAR_YELLOW  = 8'h3F;
  localparam logic [7:0] BAR_CYAN    = 8'hF8;
  localparam logic [7:0] BAR_GREEN   = 8'h38;
  localparam logic [7:0] BAR_MAGENTA = 8'hC7;
  localparam logic [7:0] BAR_RED     = 8'h07;
  localparam logic [7:0] BAR_BLUE    = 8'hC0;
  localparam logic [7:0] BAR_BLACK   = 8'h00;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_BOX   = 2'd2;
  localparam logic [1:0] MODE_GRAD  = 2'd3;

  // bit 1 = moving up, bit 0 = moving left
  typedef enum logic [1:0] {
    DR = 2'b00,
    DL = 2'b01,
    UR = 2'b10,
    UL = 2'b11
  } dir_t;

  // Eight 80-pixel-wide bars; range compares avoid a divider.
  function automatic logic [7:0] bar_color(input logic [9:0] col);
    logic [7:0] c;
    if (col < 10'd80)       c = BAR_WHITE;
    else if (col < 10'd160) c = BAR_YELLOW;
    else if (col < 10'd240) c = BAR_CYAN;
    else if (col < 10'd320) c = BAR_GREEN;
    else if (col < 10'd400) c = BAR_MAGENTA;
    else if (col < 10'd480) c = BAR_RED;
    else if (col < 10'd560) c = BAR_BLUE;
    else                    c = BAR_BLACK;
    return c;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position registers and direction FSM; advances once per tick.
module vga_box_mover #(
  parameter int XMAX = 608,
  parameter int YMAX = 448,
  parameter int STEP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  output logic [9:0] bx,
  output logic [9:0] by
);
  import vga_pkg::*;

  localparam logic [9:0] XMAX_W = 10'(XMAX);
  localparam logic [9:0] YMAX_W = 10'(YMAX);
  localparam logic [9:0] STEP_W = 10'(STEP);

  // Returns {moving_negative_next, position_next} for one axis.
  function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic neg,
                                            input logic [9:0] lim, input logic [9:0] stp);
    logic [10:0] r;
    if (!neg) begin
      if (({1'b0, pos} + {1'b0, stp}) >= {1'b0, lim}) r = {1'b1, lim};
      else                                            r = {1'b0, pos + stp};
    end else begin
      if (pos <= stp) r = {1'b0, 10'd0};
      else            r = {1'b1, pos - stp};
    end
    return r;
  endfunction

  logic [9:0]  bx_r;
  logic [9:0]  by_r;
  dir_t        dir_r;
  logic        left_s;
  logic        up_s;
  logic [10:0] x_nxt_s;
  logic [10:0] y_nxt_s;
  dir_t        dir_nxt_s;

  // Decode the direction state into per-axis movement bits.
  always_comb begin
    left_s = 1'b0;
    up_s   = 1'b0;
    case (dir_r)
      DR:      begin left_s = 1'b0; up_s = 1'b0; end
      DL:      begin left_s = 1'b1; up_s = 1'b0; end
      UR:      begin left_s = 1'b0; up_s = 1'b1; end
      UL:      begin left_s = 1'b1; up_s = 1'b1; end
      default: begin left_s = 1'b0; up_s = 1'b0; end
    endcase
  end

  // Next position per axis; each axis flips only its own direction bit.
  always_comb begin
    x_nxt_s = axis_next(bx_r, left_s, XMAX_W, STEP_W);
    y_nxt_s = axis_next(by_r, up_s, YMAX_W, STEP_W);
    case ({y_nxt_s[10], x_nxt_s[10]})
      2'b00:   dir_nxt_s = DR;
      2'b01:   dir_nxt_s = DL;
      2'b10:   dir_nxt_s = UR;
      2'b11:   dir_nxt_s = UL;
      default: dir_nxt_s = DR;
    endcase
  end

  // Position/direction state, updated only on a frame tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      bx_r  <= 10'd0;
      by_r  <= 10'd0;
      dir_r <= DR;
    end else if (tick) begin
      bx_r  <= x_nxt_s[9:0];
      by_r  <= y_nxt_s[9:0];
      dir_r <= dir_nxt_s;
    end else begin
      bx_r  <= bx_r;
      by_r  <= by_r;
      dir_r <= dir_r;
    end
  end

  assign bx = bx_r;
  assign by = by_r;

endmodule

// File: rtl/vga_pattern_gen.sv
// Per-pixel colour source: frame-tick detection, mode latch, frame counter, colour mux.
module vga_pattern_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       de,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vs,
  input  logic [1:0] mode,
  output logic [7:0] data,
  output logic       de_out,
  output logic [7:0] frame_cnt
);
  import vga_pkg::*;

  localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

  logic       vs_r;
  logic [1:0] mode_r;
  logic [7:0] frame_cnt_r;
  logic [7:0] data_r;
  logic       de_out_r;
  logic       tick_s;
  logic       in_box_s;
  logic [7:0] color_s;
  logic [9:0] bx_s;
  logic [9:0] by_s;

  // Falling edge of vs seen on a pixel-enable cycle marks a new frame.
  assign tick_s = pix_en & vs_r & ~vs;

  vga_box_mover #(
    .XMAX (H_ACTIVE - BOX_SIZE),
    .YMAX (V_ACTIVE - BOX_SIZE),
    .STEP (STEP)
  ) u_box (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s),
    .bx    (bx_s),
    .by    (by_s)
  );

  // 11-bit compares so bx+BOX_SIZE never wraps.
  assign in_box_s = ({1'b0, x} >= {1'b0, bx_s}) && ({1'b0, x} < ({1'b0, bx_s} + BOX_W)) &&
                    ({1'b0, y} >= {1'b0, by_s}) && ({1'b0, y} < ({1'b0, by_s} + BOX_W));

  // Select the colour for the current pixel using the frame-latched mode.
  always_comb begin
    color_s = 8'h00;
    if (de) begin
      case (mode_r)
        MODE_BARS:  color_s = bar_color(x);
        MODE_CHECK: color_s = (x[5] ^ y[5]) ? 8'hFF : 8'h00;
        MODE_BOX:   color_s = in_box_s ? BAR_GREEN : 8'h00;
        MODE_GRAD:  color_s = x[7:0] + y[7:0];
        default:    color_s = 8'h00;
      endcase
    end else begin
      color_s = 8'h00;
    end
  end

  // Frame-level state: vs history, mode latch and frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      vs_r        <= 1'b1;
      mode_r      <= MODE_BARS;
      frame_cnt_r <= 8'd0;
    end else if (pix_en) begin
      vs_r <= vs;
      if (tick_s) begin
        mode_r      <= mode;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        mode_r      <= mode_r;
        frame_cnt_r <= frame_cnt_r;
      end
    end else begin
      vs_r        <= vs_r;
      mode_r      <= mode_r;
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Registered pixel outputs, one pixel behind the incoming coordinates.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_r   <= 8'h00;
      de_out_r <= 1'b0;
    end else if (pix_en) begin
      data_r   <= color_s;
      de_out_r <= de;
    end else begin
      data_r   <= data_r;
      de_out_r <= de_out_r;
    end
  end

  assign data      = data_r;
  assign de_out    = de_out_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed scoreboard bench for vga_pattern_gen.
module tb_vga_pattern_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic       vs;
  logic [1:0] mode;
  logic [7:0] data;
  logic       de_out;
  logic [7:0] frame_cnt;

  always #10 clock = ~clock;

  vga_pattern_gen dut (
    .clock     (clock),
    .reset     (reset),
    .pix_en    (pix_en),
    .de        (de),
    .x         (x),
    .y         (y),
    .vs        (vs),
    .mode      (mode),
    .data      (data),
    .de_out    (de_out),
    .frame_cnt (frame_cnt)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int         bx_m, by_m, dx_m, dy_m, fc_m;
  logic [1:0] mode_m;
  logic       vs_m;
  logic [7:0] bars_m [8] = '{8'hFF, 8'h3F, 8'hF8, 8'h38, 8'hC7, 8'h07, 8'hC0, 8'h00};

  typedef struct {
    logic [7:0] data;
    logic       de;
    string      tag;
  } exp_t;
  exp_t sb[$];

  function automatic void model_reset();
    bx_m = 0; by_m = 0; dx_m = 2; dy_m = 2;
    fc_m = 0; mode_m = 2'd0; vs_m = 1'b1;
  endfunction

  function automatic void move_axis(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + 2 >= lim) begin p = lim; d = -2; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 2; end
      else p = p - 2;
    end
  endfunction

  function automatic logic [7:0] color_m(input int xi, input int yi, input logic dei);
    logic [7:0] c;
    c = 8'h00;
    if (dei) begin
      case (mode_m)
        2'd0: c = bars_m[xi / 80];
        2'd1: c = (((xi / 32) % 2) != ((yi / 32) % 2)) ? 8'hFF : 8'h00;
        2'd2: c = (xi >= bx_m && xi < bx_m + 32 && yi >= by_m && yi < by_m + 32) ? 8'h38 : 8'h00;
        default: c = 8'((xi + yi) % 256);
      endcase
    end
    return c;
  endfunction

  // One clock with the given inputs; afterwards compare any expected output.
  task automatic drive(input int xi, input int yi, input logic dei, input logic vsi,
                       input logic pe, input logic rst);
    exp_t e;
    @(negedge clock);
    x = 10'(xi); y = 10'(yi); de = dei; vs = vsi; pix_en = pe; reset = rst;
    if (rst) begin
      model_reset();
    end else if (pe) begin
      if (vs_m && !vsi) begin
        mode_m = mode;
        fc_m = (fc_m + 1) % 256;
        move_axis(bx_m, dx_m, 608);
        move_axis(by_m, dy_m, 448);
      end
      vs_m = vsi;
    end
    @(posedge clock);
    #1;
    pix_en = 1'b0;
    reset  = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (data === e.data) else begin
        bad++;
        $error("FAIL %s: data=%h expected %h", e.tag, data, e.data);
      end
      total++;
      assert (de_out === e.de) else begin
        bad++;
        $error("FAIL %s: de_out=%b expected %b", e.tag, de_out, e.de);
      end
    end
  endtask

  task automatic px(input int xi, input int yi, input logic dei, input string tag);
    exp_t e;
    e.data = color_m(xi, yi, dei);
    e.de   = dei;
    e.tag  = tag;
    sb.push_back(e);
    drive(xi, yi, dei, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int xi, input int yi, input logic dei, input string tag);
    exp_t e;
    e.data = 8'h00;
    e.de   = 1'b0;
    e.tag  = tag;
    sb.push_back(e);
    drive(xi, yi, dei, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic tick();
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_fc(input string tag);
    total++;
    assert (frame_cnt === 8'(fc_m)) else begin
      bad++;
      $error("FAIL %s: frame_cnt=%0d expected %0d", tag, frame_cnt, fc_m);
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; de = 1'b0; vs = 1'b1;
    x = 10'd0; y = 10'd0; mode = 2'd0;
    model_reset();

    // reset state
    do_reset(0, 0, 1'b0, "reset0");
    do_reset(0, 0, 1'b0, "reset1");
    chk_fc("reset_fc");

    // colour bars
    px(0,   0, 1'b1, "bar_x0");
    px(80,  0, 1'b1, "bar_x80");
    px(320, 0, 1'b1, "bar_x320");
    px(639, 0, 1'b1, "bar_x639");

    // checkerboard
    mode = 2'd1;
    tick();
    px(31,  0,   1'b1, "chk_31_0");
    px(32,  0,   1'b1, "chk_32_0");
    px(32,  32,  1'b1, "chk_32_32");
    px(100, 100, 1'b0, "chk_de0");

    // mode change mid-frame waits for the next vs fall
    mode = 2'd0;
    tick();
    mode = 2'd3;
    px(200, 100, 1'b1, "midframe_bars");
    tick();
    px(200, 100, 1'b1, "grad_200_100");
    chk_fc("fc_after_3");

    // bouncing box with a mid-frame reset
    mode = 2'd2;
    repeat (10) tick();
    px(20, 20, 1'b1, "box_10");
    do_reset(50, 50, 1'b1, "rst_mid");
    chk_fc("rst_mid_fc");
    px(0, 0, 1'b1, "rst_mode_bars");
    tick();
    px(2,  2,  1'b1, "box_at_2");
    px(1,  2,  1'b1, "box_left_of_2");
    px(33, 33, 1'b1, "box_far_corner");
    px(34, 2,  1'b1, "box_right_edge");
    for (int i = 1; i < 224; i++) tick();
    px(bx_m, 448, 1'b1, "by_448");
    px(bx_m, 447, 1'b1, "by_447");
    tick();
    px(bx_m, 446, 1'b1, "by_flip_446");
    px(bx_m, 478, 1'b1, "by_flip_478");
    for (int i = 225; i < 256; i++) tick();
    chk_fc("fc_wrap");
    for (int i = 256; i < 304; i++) tick();
    chk_fc("fc_304");
    px(608, by_m, 1'b1, "bx_608");
    px(607, by_m, 1'b1, "bx_607");
    px(639, by_m, 1'b1, "bx_639");
    tick();
    px(606, by_m, 1'b1, "bx_606");
    px(605, by_m, 1'b1, "bx_605");
    px(638, by_m, 1'b1, "bx_638");

    // vs falling while pix_en=0 is not a frame tick
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_fc("no_tick_fc");
    px(606, by_m, 1'b1, "no_tick_box");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Pixel-data source for the Spartan-3E VGA output path. It sits directly upstream of the 640x480 sync/timing stage. It takes that stage's pixel coordinates, display-enable and vertical sync, and returns one 8-bit 3-3-2 colour word per pixel. Four selectable patterns are provided: colour bars, checkerboard, bouncing box and gradient. Pattern animation and the mode change take effect once per frame, so the image never tears.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_SIZE, 32, bouncing-box edge in pixels
- STEP, 2, box displacement per frame on each axis, in pixels

Ports:
- clock  in  1  board clock (50 MHz); the only clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- pix_en  in  1  pixel-rate (25 MHz) enable from the timing stage; one clock-cycle pulse per pixel
- de  in  1  display-enable; high while x,y are inside the visible area
- x  in  10  pixel column, 0..H_ACTIVE-1 while de=1
- y  in  10  pixel row, 0..V_ACTIVE-1 while de=1
- vs  in  1  vertical sync, active low
- mode  in  2  pattern select; 0 bars, 1 checker, 2 box, 3 gradient
- data  out  8  colour word {b[1:0], g[2:0], r[2:0]}; data[7:6]=b, [5:3]=g, [2:0]=r
- de_out  out  1  de delayed to match data
- frame_cnt  out  8  frames since reset; wraps 255->0

## Operation
- All state advances only on clock edges where pix_en=1, except reset. Reset takes priority over every other event.
- Reset values: data=0x00, de_out=0, frame_cnt=0, mode_q=0, bx=0, by=0, direction state DR (right and down), vs_q=1.
- **Frame tick:** one pix_en cycle where vs_q=1 and vs=0, i.e. the falling edge of vs. vs_q is updated every pix_en cycle.
- **On frame tick:**
  - mode_q <= mode. A mode change mid-frame is ignored until the next tick.
  - frame_cnt increments.
  - The box advances one step.
- **Box move:** XMAX=H_ACTIVE-BOX_SIZE (608), YMAX=V_ACTIVE-BOX_SIZE (448).
  - Moving right: if bx+STEP >= XMAX, then bx<=XMAX and the direction flips to left; else bx<=bx+STEP.
  - Moving left: if bx <= STEP, then bx<=0 and the direction flips to right; else bx<=bx-STEP.
  - The y axis follows the same rules independently, using YMAX.
  - Direction FSM states: DR, DL, UR, UL. Each axis flips only its own bit, and both may flip on the same tick.
- **Colour per pixel**, when de=1 (patterns use mode_q):
  - Mode 0, bars: index = x/80. Index 0..7 maps to 0xFF white, 0x3F yellow, 0xF8 cyan, 0x38 green, 0xC7 magenta, 0x07 red, 0xC0 blue, 0x00 black.
  - Mode 1, checker: (x[5]^y[5]) ? 0xFF : 0x00.
  - Mode 2, box: 0x38 if bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE; else 0x00.
  - Mode 3, gradient: (x[7:0]+y[7:0]) mod 256.
  - de=0: data=0x00, regardless of mode.
- All arithmetic is unsigned 10-bit. Comparisons use 11-bit sums, so bx+BOX_SIZE cannot wrap.

## Timing
- Latency: data and de_out are registered. They reflect the x, y and de sampled on the previous pix_en cycle, which is one pixel of latency. The timing stage compensates by delaying sync by one pixel.
- Outputs hold their value between pix_en pulses.
- Box position and mode_q change on the frame-tick cycle, during vertical sync. The change first appears on the next visible frame.
- A second vs falling edge cannot occur within a frame. No special handling is required.
- Reset mid-frame: outputs are 0 on the next clock edge. The first frame tick after reset release uses mode and moves the box from (0,0) to (2,2).

## Structure
- Shared package vga_pkg holds:
  - H_ACTIVE and V_ACTIVE constants
  - the eight bar-colour constants
  - mode encodings MODE_BARS, MODE_CHECK, MODE_BOX, MODE_GRAD
  - direction state encodings DR, DL, UR, UL
- One sub-module, vga_box_mover: the bx/by registers and direction FSM. Its inputs are clock, reset and tick; its outputs are bx and by.
- The top level holds vs edge detection, mode_q, frame_cnt and the registered colour mux.

## Test plan
- Reset, then mode=0, de=1, drive x=0, 80, 320, 639 on successive pix_en -> data one pixel later is 0xFF, 0x3F, 0xC7, 0x00. de_out=1.
- Mode=1: (x,y)=(31,0) -> 0x00; (32,0) -> 0xFF; (32,32) -> 0x00. de=0 at any (x,y) -> 0x00 with de_out=0.
- Mode=2 from reset, 304 frame ticks -> bx=608, direction left, frame_cnt=48. Tick 305 -> bx=606. After 224 ticks, by=448 and the y direction flips on the same tick.
- Mode switched 0->3 mid-frame -> data still shows bars until the next vs fall. Afterwards, (x,y)=(200,100) -> 0x2C.
- Assert reset for one clock mid-frame after 10 ticks -> next edge: data=0, frame_cnt=0, bx=by=0. The next tick gives bx=by=2.
- 256 frame ticks -> frame_cnt wraps to 0. A pix_en=0 cycle with vs falling produces no tick.
